bcd_stream_to_binary: RTL and testbench
=======================================

// Module: bcd_stream_to_binary
// PURPOSE
//  Downstream consumer of the excess-3 -> BCD converter. Accepts a serial stream of
//  BCD digits (most significant digit first) over a valid/ready handshake.
//  Accumulates value = value*10 + digit and presents the packed binary result
//  with a digit count and an invalid-digit error flag on a second valid/ready port.
//  It sits between the digit converter and any binary arithmetic or display logic.
// PARAMETERS
//  NUM_DIGITS  4   maximum digits per frame; a frame closes at this count or on in_last
//  OUT_W       14  result width; must be >= ceil(log2(10^NUM_DIGITS)), else result is mod 2^OUT_W
//  CNT_W       3   digit-count width; must hold NUM_DIGITS
// PORTS
//  clk        in   1      single clock; all logic samples on the rising edge
//  rst        in   1      synchronous, active-high reset
//  in_digit   in   4      BCD digit; legal values are 0..9
//  in_last    in   1      marks the final digit of a short frame; qualified by the transfer
//  in_valid   in   1      in_digit and in_last are valid
//  in_ready   out  1      block can accept a digit this cycle
//  out_bin    out  OUT_W  binary value of the frame
//  out_count  out  CNT_W  number of digits accepted in the frame (1..NUM_DIGITS)
//  out_err    out  1      at least one digit in the frame was > 9
//  out_valid  out  1      out_bin, out_count and out_err are valid
//  out_ready  in   1      the sink accepts the result
// BEHAVIOUR
//  - States: ACC (collect digits) and DONE (hold the result). Reset state is ACC.
//  - Reset values: out_bin=0, out_count=0, out_err=0, out_valid=0. Accumulator and counter are cleared.
//  - in_ready = (state==ACC). It reads 1 in the first cycle after rst deasserts.
//    Handshakes in a cycle where rst=1 are ignored.
//  - In-transfer = in_valid & in_ready. On each in-transfer:
//    acc <= acc*10 + d, where d = in_digit if in_digit <= 9, else d = 0 and the error flag is set.
//    cnt <= cnt+1.
//  - acc*10 is computed as (acc<<3)+(acc<<1) at OUT_W+4 bits, then truncated to OUT_W.
//  - Frame end: an in-transfer with in_last=1, or the NUM_DIGITS-th in-transfer. That transfer is
//    included in the result. Next cycle: state=DONE, out_valid=1, outputs carry the final
//    acc/cnt/err. Latency is 1 cycle from the last digit to out_valid.
//  - In DONE: outputs are stable and in_ready=0 until out_valid & out_ready.
//    The cycle after that: state=ACC, out_valid=0, acc/cnt/err cleared. This gives exactly
//    1 bubble cycle; input is never accepted in the same cycle as the output handshake.
//  - out_bin, out_count and out_err keep their last values while out_valid=0. They are only
//    meaningful when out_valid=1.
//  - in_last on an in-transfer at the NUM_DIGITS-th digit: one frame end, not two.
//  - No digits before in_last: not possible, because a frame always contains >= 1 digit.
//  - Error is sticky within a frame and cleared only on output handshake or reset.
//  - rst mid-frame or in DONE: partial frame or pending result discarded, back to ACC,
//    all outputs at reset values.
//  - in_valid may drop without the transfer completing; the block has no timeout.
// STRUCTURE
//  - Shared package bcd_pkg:
//    DIGIT_W=4, BCD_MAX=4'd9, state enum {ST_ACC, ST_DONE}, function is_bcd(d).
//    The converter and its siblings use the same package.
//  - Sub-module bcd_mac10: combinational, acc_in[OUT_W-1:0], digit[3:0] -> acc_out = acc_in*10 + digit.
//    Implemented with shift-add only; no multiplier.
//  - Top level: state register, counter, accumulator, error flag, output register.
// TESTING
//  1. Digits 1,2,3,4, in_last=0, out_ready=1
//     -> out_valid 1 cycle after the 4th digit; out_bin=1234 (0x4D2), out_count=4, out_err=0.
//  2. Digits 0,7 with in_last on 7 -> out_bin=7, out_count=2, out_err=0.
//     in_ready=0 only for the DONE cycle.
//  3. Digits 9,4'b1010,9,9 -> out_err=1, out_bin=9099, out_count=4.
//     The following frame 0,0,0,1 -> out_err=0, out_bin=1.
//  4. Frame 9,9,9,9 with out_ready=0 for 5 cycles -> out_bin=9999 (0x270F) held stable for
//     all 5 cycles, in_ready=0 throughout. The next frame is accepted only after the handshake.
//  5. Digits 3,8, then rst for 1 cycle, then 5,6,7,8 -> a single output 5678, out_count=4.
//     No output is produced for the aborted frame.
//  6. in_valid toggled randomly and in_last on the 3rd digit of 2,0,5
//     -> out_bin=205, out_count=3. Digits are transferred only on cycles with in_valid & in_ready.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD definitions used by the digit converter and its downstream consumers.
//   DIGIT_W : width of one BCD digit
//   BCD_MAX : largest legal BCD digit value
//   state_t : frame-assembly state (collect digits / hold result)
//   is_bcd  : true when a 4-bit code is a legal decimal digit
package bcd_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic {
    ST_ACC,
    ST_DONE
  } state_t;

  function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_mac10.sv
// Combinational decimal multiply-accumulate step: acc_out = acc_in*10 + digit (mod 2^OUT_W).
// Ports:
//   acc_in  : running binary value
//   digit   : digit to append (caller guarantees 0..9)
//   acc_out : updated value, truncated to OUT_W bits
module bcd_mac10
  import bcd_pkg::*;
#(
  parameter int unsigned OUT_W = 14
) (
  input  logic [OUT_W-1:0]   acc_in,
  input  logic [DIGIT_W-1:0] digit,
  output logic [OUT_W-1:0]   acc_out
);

  // x*10 = x*8 + x*2. Bits above OUT_W never reach the result, so the sum is formed at OUT_W
  // bits directly; this equals truncating the full-width product.
  logic [OUT_W-1:0] times8;
  logic [OUT_W-1:0] times2;

  always_comb begin
    times8  = acc_in << 3;
    times2  = acc_in << 1;
    acc_out = times8 + times2 + OUT_W'(digit);
  end

endmodule

// File: rtl/bcd_stream_to_binary.sv
// Collects a serial, MSD-first stream of BCD digits into a binary value and presents it with
// a digit count and an invalid-digit flag.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   in_digit  : BCD digit (legal 0..9)
//   in_last   : final digit of a short frame
//   in_valid  : input handshake valid
//   in_ready  : block accepts a digit this cycle
//   out_bin   : binary value of the frame
//   out_count : digits in the frame (1..NUM_DIGITS)
//   out_err   : at least one digit in the frame was > 9
//   out_valid : result handshake valid
//   out_ready : sink accepts the result
module bcd_stream_to_binary
  import bcd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned OUT_W      = 14,
  parameter int unsigned CNT_W      = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIGIT_W-1:0] in_digit,
  input  logic               in_last,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [OUT_W-1:0]   out_bin,
  output logic [CNT_W-1:0]   out_count,
  output logic               out_err,
  output logic               out_valid,
  input  logic               out_ready
);

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [OUT_W-1:0]   bin_q, bin_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               oerr_q, oerr_d;

  logic               in_xfer;
  logic               digit_ok;
  logic [DIGIT_W-1:0] digit_eff;
  logic [OUT_W-1:0]   acc_mac;
  logic [CNT_W-1:0]   cnt_inc;
  logic               err_new;
  logic               frame_end;

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_DONE);
  assign out_bin   = bin_q;
  assign out_count = count_q;
  assign out_err   = oerr_q;

  assign in_xfer   = in_valid & in_ready;
  assign digit_ok  = is_bcd(in_digit);
  // Illegal digits contribute zero but poison the frame via the error flag.
  assign digit_eff = digit_ok ? in_digit : '0;
  assign cnt_inc   = cnt_q + 1'b1;
  assign err_new   = err_q | ~digit_ok;
  // in_last on the final allowed digit still closes only one frame.
  assign frame_end = in_xfer & (in_last | (cnt_inc == CNT_W'(NUM_DIGITS)));

  bcd_mac10 #(
    .OUT_W (OUT_W)
  ) u_mac10 (
    .acc_in  (acc_q),
    .digit   (digit_eff),
    .acc_out (acc_mac)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    bin_d   = bin_q;
    count_d = count_q;
    oerr_d  = oerr_q;

    unique case (state_q)
      ST_ACC: begin
        if (in_xfer) begin
          acc_d = acc_mac;
          cnt_d = cnt_inc;
          err_d = err_new;
          if (frame_end) begin
            state_d = ST_DONE;
            bin_d   = acc_mac;
            count_d = cnt_inc;
            oerr_d  = err_new;
          end
        end
      end
      ST_DONE: begin
        // Result registers keep their value after the handshake; only the working state clears.
        if (out_ready) begin
          state_d = ST_ACC;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      bin_q   <= '0;
      count_q <= '0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      bin_q   <= bin_d;
      count_q <= count_d;
      oerr_q  <= oerr_d;
    end
  end

endmodule

// File: tb/tb_bcd_stream_to_binary.sv
// Self-checking bench for bcd_stream_to_binary: directed frames plus random frames, each
// compared against a decimal-arithmetic model of the frame.
module tb_bcd_stream_to_binary;

  localparam int NUM_DIGITS = 4;
  localparam int OUT_W      = 14;
  localparam int CNT_W      = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       in_digit;
  logic             in_last;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] out_bin;
  logic [CNT_W-1:0] out_count;
  logic             out_err;
  logic             out_valid;
  logic             out_ready;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  bcd_stream_to_binary #(
    .NUM_DIGITS (NUM_DIGITS),
    .OUT_W      (OUT_W),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_digit  (in_digit),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_bin   (out_bin),
    .out_count (out_count),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // digs holds up to four digits, MSD in bits [15:12]. last_at is the index carrying in_last
  // (-1 for none). Up to 3 idle cycles may precede each digit with probability gap_pct.
  // hold is the number of DONE cycles with out_ready low before the handshake.
  task automatic run_frame(input string name, input logic [15:0] digs, input int n,
                           input int last_at, input int gap_pct, input int hold);
    int         exp_val;
    int         exp_cnt;
    bit         exp_err;
    logic [3:0] dg;
    exp_val = 0;
    exp_cnt = 0;
    exp_err = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < 3 && $urandom_range(0, 99) < gap_pct; g++) begin
        in_valid = 1'b0;
        in_digit = 4'($urandom);
        in_last  = 1'($urandom);
        tick();
      end
      dg       = digs[15-4*i -: 4];
      in_valid = 1'b1;
      in_digit = dg;
      in_last  = (i == last_at);
      check({name, ".in_ready"}, 32'(in_ready), 32'd1);
      exp_err = exp_err | (dg > 9);
      exp_val = (exp_val * 10 + ((dg > 9) ? 0 : int'(dg))) % (1 << OUT_W);
      exp_cnt++;
      tick();
      if (i == last_at || exp_cnt == NUM_DIGITS) break;
      check({name, ".mid_valid"}, 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check({name, ".out_valid"}, 32'(out_valid), 32'd1);
    check({name, ".out_bin"},   32'(out_bin),   32'(exp_val));
    check({name, ".out_count"}, 32'(out_count), 32'(exp_cnt));
    check({name, ".out_err"},   32'(out_err),   32'(exp_err));
    check({name, ".done_ready"}, 32'(in_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      // Offered digits must be refused while the result is pending.
      in_valid = 1'($urandom);
      in_digit = 4'($urandom_range(0, 9));
      tick();
      check({name, ".hold_valid"}, 32'(out_valid), 32'd1);
      check({name, ".hold_bin"},   32'(out_bin),   32'(exp_val));
      check({name, ".hold_ready"}, 32'(in_ready),  32'd0);
    end
    // A digit offered during the output handshake must not be taken.
    in_valid  = 1'b1;
    in_digit  = 4'd7;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check({name, ".post_valid"}, 32'(out_valid), 32'd0);
    check({name, ".post_ready"}, 32'(in_ready),  32'd1);
    check({name, ".post_bin"},   32'(out_bin),   32'(exp_val));
  endtask

  initial begin
    logic [15:0] rd;
    int          rn;
    int          rl;
    rst       = 1'b1;
    in_digit  = 4'd0;
    in_last   = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.out_bin",   32'(out_bin),   32'd0);
    check("reset.out_count", 32'(out_count), 32'd0);
    check("reset.out_err",   32'(out_err),   32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    check("reset.in_ready", 32'(in_ready), 32'd1);

    run_frame("t1_1234", 16'h1234, 4, -1, 0, 0);
    run_frame("t2_07",   16'h0700, 2, 1, 0, 0);
    run_frame("t3_err",  16'h9A99, 4, -1, 0, 0);
    run_frame("t3_0001", 16'h0001, 4, -1, 0, 0);
    run_frame("t4_9999", 16'h9999, 4, -1, 0, 5);

    // Reset mid-frame: partial frame dropped, and a transfer offered under reset is ignored.
    in_valid = 1'b1;
    in_digit = 4'd3;
    tick();
    in_digit = 4'd8;
    tick();
    rst      = 1'b1;
    in_digit = 4'd9;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("t5.rst_valid", 32'(out_valid), 32'd0);
    check("t5.rst_bin",   32'(out_bin),   32'd0);
    check("t5.rst_count", 32'(out_count), 32'd0);
    check("t5.rst_ready", 32'(in_ready),  32'd1);
    run_frame("t5_5678", 16'h5678, 4, -1, 0, 0);

    run_frame("t6_205", 16'h2050, 3, 2, 60, 1);

    // in_last on the fourth digit is a single frame end.
    run_frame("last4", 16'h4321, 4, 3, 0, 0);

    // Reset while a result is pending.
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_digit = 4'd6;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("rst_done.pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_done.valid", 32'(out_valid), 32'd0);
    check("rst_done.bin",   32'(out_bin),   32'd0);
    check("rst_done.ready", 32'(in_ready),  32'd1);

    for (int f = 0; f < 25; f++) begin
      rn = $urandom_range(1, 4);
      rd = 16'h0;
      for (int k = 0; k < 4; k++) begin
        rd[15-4*k -: 4] = ($urandom_range(0, 99) < 15) ? 4'($urandom_range(10, 15))
                                                      : 4'($urandom_range(0, 9));
      end
      if (rn < 4) rl = rn - 1;
      else rl = ($urandom_range(0, 1) == 1) ? 3 : -1;
      run_frame("rand", rd, rn, rl, 30, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
